player_label_sequencer: RTL and testbench

//  Drives a two-digit 7-seg player label "P<n>" for N players (n = 1..NUM_PLAYERS).

---
 rtl/player_label_sequencer.sv | 145 ++++++++++++++
 tb/tb_player_label_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/player_label_sequencer.sv
// Two-digit 7-seg player label "P<n>" with round-robin turn index.
// Optional blink-on-win feature is built only when LABEL_BLINK_EN is defined.
module player_label_sequencer #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned BLINK_DIV   = 25000000,
    localparam int unsigned IDX_W      = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             next_btn,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             hold,
    input  logic             win,
    output logic [IDX_W-1:0] player_idx,
    output logic             turn_pulse,
    output logic [6:0]       seg_P,
    output logic [6:0]       seg_num
);

    localparam logic [6:0] SEG_LETTER_P = 7'b0001100;
    localparam logic [6:0] SEG_BLANK    = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT_1  = 7'b1111001;

    logic             btn_q;
    logic             rise_c;
    logic             load_ok_c;
    logic [IDX_W-1:0] idx_nxt_c;
    logic             pulse_nxt_c;
    logic             blank_nxt_c;

    // Active-low gfedcba pattern for the 1-based player number
    function automatic logic [6:0] digit_seg(input logic [IDX_W-1:0] idx);
        logic [6:0] seg;
        case (4'(idx))
            4'd0:    seg = 7'b1111001;
            4'd1:    seg = 7'b0100100;
            4'd2:    seg = 7'b0110000;
            4'd3:    seg = 7'b0011001;
            4'd4:    seg = 7'b0010010;
            4'd5:    seg = 7'b0000010;
            4'd6:    seg = 7'b1111000;
            4'd7:    seg = 7'b0000000;
            4'd8:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    assign rise_c    = next_btn & ~btn_q;
    assign load_ok_c = load_en && (32'(load_idx) < NUM_PLAYERS);

    // Next turn index: a load strobe always masks a same-cycle button edge
    always_comb begin
        idx_nxt_c   = player_idx;
        pulse_nxt_c = 1'b0;
        if (load_en) begin
            if (load_ok_c) begin
                idx_nxt_c   = load_idx;
                pulse_nxt_c = (load_idx != player_idx);
            end
        end else if (rise_c && !hold) begin
            idx_nxt_c   = (player_idx == IDX_W'(NUM_PLAYERS - 1)) ? '0 : player_idx + IDX_W'(1);
            pulse_nxt_c = 1'b1;
        end
    end

    // Turn index, change pulse and button history; btn_q tracks the button through reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            player_idx <= '0;
            turn_pulse <= 1'b0;
            btn_q      <= next_btn;
        end else begin
            player_idx <= idx_nxt_c;
            turn_pulse <= pulse_nxt_c;
            btn_q      <= next_btn;
        end
    end

`ifdef LABEL_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        SHOW   = 2'd0,
        BL_ON  = 2'd1,
        BL_OFF = 2'd2
    } blink_state_t;

    blink_state_t     state;
    blink_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Blink state and half-period counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SHOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Blink sequencing: win starts an ON/OFF cycle of BLINK_DIV cycles per half
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            SHOW: begin
                if (win) state_nxt = BL_ON;
            end
            BL_ON, BL_OFF: begin
                if (!win) begin
                    state_nxt = SHOW;
                end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
                    state_nxt = (state == BL_ON) ? BL_OFF : BL_ON;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = SHOW;
        endcase
    end

    assign blank_nxt_c = (state_nxt == BL_OFF);
`else
    logic unused_cfg_c;
    assign unused_cfg_c = win | (BLINK_DIV < 2);
    assign blank_nxt_c  = 1'b0;
`endif

    // Display registers; blanking follows the blink state in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_P   <= SEG_LETTER_P;
            seg_num <= SEG_DIGIT_1;
        end else begin
            seg_P   <= blank_nxt_c ? SEG_BLANK : SEG_LETTER_P;
            seg_num <= blank_nxt_c ? SEG_BLANK : digit_seg(player_idx);
        end
    end

endmodule

// File: tb/tb_player_label_sequencer.sv
// Directed bench for player_label_sequencer (NUM_PLAYERS=4 main, NUM_PLAYERS=5 for out-of-range load).
module tb_player_label_sequencer;

    logic       clk;
    logic       rst_n;
    logic       next_btn;
    logic       load_en;
    logic [1:0] load_idx;
    logic [2:0] load_idx5;
    logic       hold;
    logic       win;
    logic [1:0] player_idx;
    logic       turn_pulse;
    logic [6:0] seg_P;
    logic [6:0] seg_num;
    logic [2:0] player_idx5;
    logic       turn_pulse5;
    logic [6:0] seg_P5;
    logic [6:0] seg_num5;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] P_SEG = 7'b0001100;
    localparam logic [6:0] BLANK = 7'b1111111;
    logic [6:0] dig [0:4];
    int blink_on;

    player_label_sequencer #(.NUM_PLAYERS(4), .BLINK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .next_btn(next_btn), .load_en(load_en),
        .load_idx(load_idx), .hold(hold), .win(win), .player_idx(player_idx),
        .turn_pulse(turn_pulse), .seg_P(seg_P), .seg_num(seg_num)
    );

    player_label_sequencer #(.NUM_PLAYERS(5), .BLINK_DIV(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .next_btn(next_btn), .load_en(load_en),
        .load_idx(load_idx5), .hold(hold), .win(win), .player_idx(player_idx5),
        .turn_pulse(turn_pulse5), .seg_P(seg_P5), .seg_num(seg_num5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_idx [0:3];
        logic [2:0] exp_idx5 [0:3];
        logic [6:0] exp_dig [0:3];
        logic       blank;

        dig[0] = 7'b1111001; dig[1] = 7'b0100100; dig[2] = 7'b0110000;
        dig[3] = 7'b0011001; dig[4] = 7'b0010010;
        exp_idx[0] = 2'd1; exp_idx[1] = 2'd2; exp_idx[2] = 2'd3; exp_idx[3] = 2'd0;
        exp_idx5[0] = 3'd1; exp_idx5[1] = 3'd2; exp_idx5[2] = 3'd3; exp_idx5[3] = 3'd4;
        exp_dig[0] = dig[1]; exp_dig[1] = dig[2]; exp_dig[2] = dig[3]; exp_dig[3] = dig[0];
`ifdef LABEL_BLINK_EN
        blink_on = 1;
`else
        blink_on = 0;
`endif

        rst_n = 1'b0; next_btn = 1'b0; load_en = 1'b0; load_idx = 2'd0;
        load_idx5 = 3'd0; hold = 1'b0; win = 1'b0;

        // Reset state
        tick();
        check("rst_idx",   8'(player_idx), 8'd0);
        check("rst_pulse", 8'(turn_pulse), 8'd0);
        check("rst_segP",  8'(seg_P),      8'(P_SEG));
        check("rst_segn",  8'(seg_num),    8'(dig[0]));
        rst_n = 1'b1;
        tick();
        check("idle_pulse", 8'(turn_pulse), 8'd0);

        // Four rises: round-robin with wrap, digit lags index by one cycle
        for (int i = 0; i < 4; i++) begin
            next_btn = 1'b1;
            tick();
            check("adv_idx",    8'(player_idx),  8'(exp_idx[i]));
            check("adv_pulse",  8'(turn_pulse),  8'd1);
            check("adv_idx5",   8'(player_idx5), 8'(exp_idx5[i]));
            check("adv_seglag", 8'(seg_num),     8'((i == 0) ? dig[0] : exp_dig[i-1]));
            next_btn = 1'b0;
            tick();
            check("adv_pulse_off", 8'(turn_pulse), 8'd0);
            check("adv_segn",      8'(seg_num),    8'(exp_dig[i]));
        end

        // Direct load
        load_en = 1'b1; load_idx = 2'd2; load_idx5 = 3'd2;
        tick();
        check("load_idx",   8'(player_idx), 8'd2);
        check("load_pulse", 8'(turn_pulse), 8'd1);
        tick();
        check("load_same_idx",   8'(player_idx), 8'd2);
        check("load_same_pulse", 8'(turn_pulse), 8'd0);
        check("load_segn",       8'(seg_num),    8'(dig[2]));

        // Load beats a same-cycle rise
        load_idx = 2'd0; load_idx5 = 3'd0; next_btn = 1'b1;
        tick();
        check("load_win_idx",   8'(player_idx), 8'd0);
        check("load_win_pulse", 8'(turn_pulse), 8'd1);
        load_en = 1'b0; next_btn = 1'b0;
        tick();

        // Out-of-range load ignored and swallows a same-cycle rise
        load_en = 1'b1; load_idx5 = 3'd5; next_btn = 1'b1;
        tick();
        check("oor_idx5",   8'(player_idx5), 8'd0);
        check("oor_pulse5", 8'(turn_pulse5), 8'd0);
        check("oor_pulse",  8'(turn_pulse),  8'd0);
        load_en = 1'b0; next_btn = 1'b0;
        tick();

        // Hold discards the edge; no delayed advance when hold drops
        hold = 1'b1; next_btn = 1'b1;
        tick();
        check("hold_idx",   8'(player_idx), 8'd0);
        check("hold_pulse", 8'(turn_pulse), 8'd0);
        hold = 1'b0;
        tick();
        check("unhold_idx",   8'(player_idx), 8'd0);
        check("unhold_pulse", 8'(turn_pulse), 8'd0);
        next_btn = 1'b0;
        tick();
        next_btn = 1'b1;
        tick();
        check("post_hold_idx", 8'(player_idx), 8'd1);
        next_btn = 1'b0;
        tick();
        check("post_hold_segn", 8'(seg_num), 8'(dig[1]));

        // Blink: BLINK_DIV=4 cycles per half period, ignored when feature is absent
        win = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            blank = (blink_on != 0) && ((((k - 1) / 4) % 2) == 1);
            check("blink_segP", 8'(seg_P),   8'(blank ? BLANK : P_SEG));
            check("blink_segn", 8'(seg_num), 8'(blank ? BLANK : dig[1]));
        end
        win = 1'b0;
        tick();
        check("unblink_segP", 8'(seg_P),   8'(P_SEG));
        check("unblink_segn", 8'(seg_num), 8'(dig[1]));

        // Reset while blanked restores "P1" at the reset edge
        win = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        check("blank_before_rst", 8'(seg_P), 8'((blink_on != 0) ? BLANK : P_SEG));
        rst_n = 1'b0;
        tick();
        check("rst_blink_segP", 8'(seg_P),      8'(P_SEG));
        check("rst_blink_segn", 8'(seg_num),    8'(dig[0]));
        check("rst_blink_idx",  8'(player_idx), 8'd0);
        rst_n = 1'b1; win = 1'b0;
        tick();
        check("after_rst_segP", 8'(seg_P), 8'(P_SEG));

        // Button held through reset is not an edge afterwards
        rst_n = 1'b0; next_btn = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_btn_idx",   8'(player_idx), 8'd0);
        check("rst_btn_pulse", 8'(turn_pulse), 8'd0);
        next_btn = 1'b0;
        tick();
        next_btn = 1'b1;
        tick();
        check("rst_btn_adv", 8'(player_idx), 8'd1);
        check("rst_btn_adv_pulse", 8'(turn_pulse), 8'd1);
        next_btn = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
